reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 tb/tb_reg_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a dual-issue pipeline. Tracks destination
// registers of in-flight long-latency writers (div, load) and decides
// per cycle which decoded slots may issue without a RAW/WAW hazard or
// exceeding the outstanding-op budget.
module reg_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            d_valid_i,
  input  logic [1:0][1:0][4:0]  r_reg_i,
  input  logic [1:0][4:0]       w_reg_i,
  input  logic [1:0]            long_i,
  input  logic [1:0]            is_i,
  input  logic                  ex_ready_i,
  input  logic [1:0]            wb_valid_i,
  input  logic [1:0][4:0]       wb_reg_i,
  input  logic                  flush_i,
  output logic [1:0]            sb_ok_o,
  output logic [31:0]           pending_o,
  output logic [CW-1:0]         count_o
);

  // Largest value the count register can hold; the count saturates here
  // instead of wrapping if the issue stage ever overfills the scoreboard.
  localparam logic [6:0] CNT_SAT = 7'((1 << CW) - 1);
  localparam logic [6:0] MAX_C   = 7'(MAX_OUTSTANDING);

  logic [31:0]   pending_r;
  logic [CW-1:0] count_r;

  logic [1:0]    lw_s;
  logic [1:0]    fire_s;
  logic [1:0]    hz_s;
  logic [1:0]    full_s;
  logic [31:0]   set_mask_s;
  logic [31:0]   clr_mask_s;
  logic [31:0]   pending_next_s;
  logic [5:0]    nset_s;
  logic [5:0]    nclr_s;
  logic [6:0]    cnt_up_s;
  logic [6:0]    cnt_diff_s;
  logic [CW-1:0] count_next_s;

  // Number of ones in a 32-bit vector.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // True when register r is nonzero and awaiting a long-latency write.
  function automatic logic busy(input logic [31:0] p, input logic [4:0] r);
    return (r != 5'd0) & p[r];
  endfunction

  // Hazard/capacity decision and next-state computation.
  always_comb begin
    lw_s   = long_i & {(w_reg_i[1] != 5'd0), (w_reg_i[0] != 5'd0)};
    fire_s = is_i & {2{ex_ready_i}};

    hz_s[0] = d_valid_i[0] & (busy(pending_r, r_reg_i[0][0]) |
                              busy(pending_r, r_reg_i[0][1]) |
                              busy(pending_r, w_reg_i[0]));
    // Slot 1 also waits on a long producer in slot 0 of the same pair,
    // since that result does not exist yet when slot 1 would read it.
    hz_s[1] = (d_valid_i[1] & (busy(pending_r, r_reg_i[1][0]) |
                               busy(pending_r, r_reg_i[1][1]) |
                               busy(pending_r, w_reg_i[1]))) |
              (lw_s[0] & ((w_reg_i[0] == r_reg_i[1][0]) |
                          (w_reg_i[0] == r_reg_i[1][1]) |
                          (w_reg_i[0] == w_reg_i[1])));

    full_s[0] = lw_s[0] & (7'(count_r) == MAX_C);
    full_s[1] = lw_s[1] & ((7'(count_r) + 7'(lw_s[0])) >= MAX_C);

    sb_ok_o[0] = ~hz_s[0] & ~full_s[0];
    sb_ok_o[1] = sb_ok_o[0] & ~hz_s[1] & ~full_s[1];

    // Sets never touch r0 because lw requires a nonzero destination.
    set_mask_s = (({31'd0, fire_s[0] & lw_s[0]} << w_reg_i[0]) |
                  ({31'd0, fire_s[1] & lw_s[1]} << w_reg_i[1])) & 32'hFFFF_FFFE;
    // Only pending, non-r0 bits clear; a same-cycle set wins. Both ports
    // naming one register collapse into a single mask bit.
    clr_mask_s = (({31'd0, wb_valid_i[0]} << wb_reg_i[0]) |
                  ({31'd0, wb_valid_i[1]} << wb_reg_i[1])) &
                 32'hFFFF_FFFE & pending_r & ~set_mask_s;

    pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;

    nset_s   = popcount32(set_mask_s & ~pending_r);
    nclr_s   = popcount32(clr_mask_s);
    cnt_up_s = 7'(count_r) + 7'(nset_s);
    if (cnt_up_s >= 7'(nclr_s)) begin
      cnt_diff_s = cnt_up_s - 7'(nclr_s);
    end else begin
      cnt_diff_s = 7'd0;
    end
    if (cnt_diff_s > CNT_SAT) begin
      count_next_s = CW'(CNT_SAT);
    end else begin
      count_next_s = CW'(cnt_diff_s);
    end
  end

  // Pending bitmap and outstanding count; flush kills all in-flight ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 32'h0;
      count_r   <= '0;
    end else if (flush_i) begin
      pending_r <= 32'h0;
      count_r   <= '0;
    end else begin
      pending_r <= pending_next_s;
      count_r   <= count_next_s;
    end
  end

  assign pending_o = pending_r;
  assign count_o   = count_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a per-register model checked
// every cycle, plus hand-computed literal checks on the key scenarios.
module tb_reg_scoreboard;

  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic                 clk;
  logic                 rst;
  logic [1:0]           d_valid;
  logic [1:0][1:0][4:0] r_reg;
  logic [1:0][4:0]      w_reg;
  logic [1:0]           long_op;
  logic [1:0]           is_v;
  logic                 ex_ready;
  logic [1:0]           wb_valid;
  logic [1:0][4:0]      wb_reg;
  logic                 flush;
  logic [1:0]           sb_ok;
  logic [31:0]          pending;
  logic [CW-1:0]        count;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: one flag per architectural register plus a counter.
  bit pend_m [32];
  int cnt_m;

  reg_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .d_valid_i(d_valid), .r_reg_i(r_reg),
    .w_reg_i(w_reg), .long_i(long_op), .is_i(is_v), .ex_ready_i(ex_ready),
    .wb_valid_i(wb_valid), .wb_reg_i(wb_reg), .flush_i(flush),
    .sb_ok_o(sb_ok), .pending_o(pending), .count_o(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && pend_m[r];
  endfunction

  // Expected issue permission from the rules, using model state.
  function automatic logic [1:0] exp_ok();
    bit lw0, lw1, hz0, hz1, full0, full1, ok0, ok1;
    lw0 = long_op[0] && (w_reg[0] != 5'd0);
    lw1 = long_op[1] && (w_reg[1] != 5'd0);
    hz0 = d_valid[0] && (m_busy(r_reg[0][0]) || m_busy(r_reg[0][1]) || m_busy(w_reg[0]));
    hz1 = d_valid[1] && (m_busy(r_reg[1][0]) || m_busy(r_reg[1][1]) || m_busy(w_reg[1]));
    if (lw0 && (w_reg[0] == r_reg[1][0] || w_reg[0] == r_reg[1][1] || w_reg[0] == w_reg[1]))
      hz1 = 1'b1;
    full0 = lw0 && (cnt_m == MAXO);
    full1 = lw1 && (cnt_m + int'(lw0) >= MAXO);
    ok0 = !hz0 && !full0;
    ok1 = ok0 && !hz1 && !full1;
    return {ok1, ok0};
  endfunction

  // Model update on each rising edge (or asynchronous reset).
  always @(posedge clk or posedge rst) begin
    bit set_now [32];
    int ns, nc;
    if (rst || flush) begin
      for (int r = 0; r < 32; r++) pend_m[r] <= 1'b0;
      cnt_m <= 0;
    end else begin
      for (int r = 0; r < 32; r++) set_now[r] = 1'b0;
      for (int k = 0; k < 2; k++)
        if (is_v[k] && ex_ready && long_op[k] && w_reg[k] != 5'd0)
          set_now[w_reg[k]] = 1'b1;
      ns = 0;
      nc = 0;
      for (int r = 1; r < 32; r++) begin
        if (set_now[r]) begin
          if (!pend_m[r]) ns++;
          pend_m[r] <= 1'b1;
        end else if (pend_m[r] && ((wb_valid[0] && wb_reg[0] == r) ||
                                   (wb_valid[1] && wb_reg[1] == r))) begin
          nc++;
          pend_m[r] <= 1'b0;
        end else begin
          pend_m[r] <= pend_m[r];
        end
      end
      cnt_m <= cnt_m + ns - nc;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] pv;
    if (!rst) begin
      for (int r = 0; r < 32; r++) pv[r] = pend_m[r];
      chk("model_sb_ok", 32'(sb_ok), 32'(exp_ok()));
      chk("model_pending", pending, pv);
      chk("model_count", 32'(count), 32'(cnt_m));
    end
  end

  task automatic drv(input logic [1:0] dv, input logic [4:0] r00, r01, r10, r11, w0, w1,
                     input logic [1:0] lg, iss, wbv, input logic [4:0] wb0, wb1,
                     input logic fl);
    d_valid     = dv;
    r_reg[0][0] = r00;
    r_reg[0][1] = r01;
    r_reg[1][0] = r10;
    r_reg[1][1] = r11;
    w_reg[0]    = w0;
    w_reg[1]    = w1;
    long_op     = lg;
    is_v        = iss;
    wb_valid    = wbv;
    wb_reg[0]   = wb0;
    wb_reg[1]   = wb1;
    flush       = fl;
    #1;
  endtask

  task automatic idle();
    drv(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    ex_ready = 1'b1;
    idle();
    chk("reset_pending", pending, 32'h0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_sb_ok", 32'(sb_ok), 32'd3);
    step();
    rst = 1'b0;

    // RAW on a long divide into r5
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("raw_issue_ok", 32'(sb_ok), 32'd3);
    step();
    drv(2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("raw_count", 32'(count), 32'd1);
    chk("raw_pending", pending, 32'h0000_0020);
    chk("raw_blocked", 32'(sb_ok), 32'd0);
    step();
    drv(2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b01, 5'd5, 5'd0, 1'b0);
    chk("raw_wb_same_cycle", 32'(sb_ok), 32'd0);
    step();
    drv(2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("raw_unblocked", 32'(sb_ok), 32'd3);
    chk("raw_count_after_wb", 32'(count), 32'd0);
    step();

    // Intra-pair dependence on a long load in slot 0
    drv(2'b11, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("intra_pair", 32'(sb_ok), 32'd1);
    step();

    // Capacity: fill r1..r4, then a fifth long op is held off
    drv(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 2'b11, 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
    step();
    drv(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd4, 2'b11, 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("cap_pair2_ok", 32'(sb_ok), 32'd3);
    step();
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("cap_count_full", 32'(count), 32'd4);
    chk("cap_pending", pending, 32'h0000_001E);
    chk("cap_fifth_blocked", 32'(sb_ok), 32'd0);
    step();
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 2'b01, 2'b00, 2'b01, 5'd1, 5'd0, 1'b0);
    step();
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("cap_count_after_wb", 32'(count), 32'd3);
    chk("cap_fifth_allowed", 32'(sb_ok), 32'd3);
    step();
    drv(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b11, 5'd2, 5'd3, 1'b0);
    step();
    drv(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b11, 5'd4, 5'd6, 1'b0);
    step();
    idle();
    chk("cap_drained", 32'(count), 32'd0);

    // Both writeback ports naming the same pending register; r0 writeback
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
    step();
    drv(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b11, 5'd9, 5'd9, 1'b0);
    step();
    idle();
    chk("dual_wb_pending", pending, 32'h0);
    chk("dual_wb_count", 32'(count), 32'd0);
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
    step();
    drv(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b11, 5'd0, 5'd0, 1'b0);
    step();
    idle();
    chk("wb_r0_count", 32'(count), 32'd1);
    chk("wb_r0_pending", pending, 32'h0000_0200);

    // Set beats clear when a fire and a writeback meet on r9
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 2'b01, 2'b01, 2'b01, 5'd9, 5'd0, 1'b0);
    step();
    idle();
    chk("set_prio_pending", pending, 32'h0000_0200);
    chk("set_prio_count", 32'(count), 32'd1);
    drv(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b01, 5'd9, 5'd0, 1'b0);
    step();
    idle();

    // Flush with a coincident fire and writeback
    drv(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd8, 2'b11, 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
    step();
    idle();
    chk("flush_pre_count", 32'(count), 32'd2);
    chk("flush_pre_pending", pending, 32'h0000_0108);
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 5'd0, 2'b01, 2'b01, 2'b01, 5'd3, 5'd0, 1'b1);
    step();
    idle();
    chk("flush_pending", pending, 32'h0);
    chk("flush_count", 32'(count), 32'd0);

    // Asynchronous reset between edges, with a fire in flight
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
    step();
    drv(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd13, 5'd0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("areset_pre_count", 32'(count), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("areset_pending", pending, 32'h0);
    chk("areset_count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    idle();
    step();
    chk("areset_set_discarded", pending, 32'h0);
    chk("areset_count_after", 32'(count), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
